// File: rtl/tage_update_scheduler_pkg.sv
// tage_defines: table operation encodings and scheduler FSM states for the TAGE update path
package tage_defines;
    typedef logic [1:0] tage_op_t;
    localparam tage_op_t TAGE_OP_CTR   = 2'b00;
    localparam tage_op_t TAGE_OP_ALLOC = 2'b01;
    localparam tage_op_t TAGE_OP_UCLR  = 2'b10;
    localparam tage_op_t TAGE_OP_UDEC  = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_ALLOC, ST_SWEEP} sched_state_e;
endpackage

// File: rtl/tage_update_scheduler_fifo.sv
// tage_update_fifo: synchronous FIFO with occupancy count; pushes are dropped when full
module tage_update_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;
    assign do_push = push_i && cnt_q != (AW+1)'(DEPTH);
    assign do_pop  = pop_i && cnt_q != '0;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/tage_update_scheduler.sv
// tage_update_scheduler: owns the tagged-table write port, sequencing queued
// branch updates (counter update + allocate) and periodic useful-bit sweeps.
module tage_update_scheduler
    import tage_defines::*;
#(
    parameter int NUM_TABLES        = 4,
    parameter int FIFO_DEPTH        = 4,
    parameter int INDEX_WIDTH       = 12,
    parameter int RESET_PERIOD_EXP2 = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   upd_valid_i,
    output logic                   upd_ready_o,
    input  logic [31:0]            upd_pc_i,
    input  logic                   upd_taken_i,
    input  logic [2:0]             upd_provider_i,
    input  logic                   upd_mispredict_i,
    input  logic [NUM_TABLES-1:0]  upd_useful_i,
    output logic                   tbl_req_valid_o,
    input  logic                   tbl_ready_i,
    output logic [1:0]             tbl_op_o,
    output logic [NUM_TABLES-1:0]  tbl_sel_o,
    output logic [31:0]            tbl_pc_o,
    output logic                   tbl_taken_o,
    output logic [INDEX_WIDTH-1:0] tbl_index_o,
    output logic                   sweep_active_o,
    output logic [31:0]            alloc_fail_count_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    typedef struct packed {
        logic [31:0]           pc;
        logic                  taken;
        logic [2:0]            prov;
        logic                  mis;
        logic [NUM_TABLES-1:0] useful;
    } upd_t;
    upd_t                         in_s, head_s;
    logic [CW-1:0]                count;
    logic                         push, pop, fire, wrap, sweep_done, go_alloc;
    logic [NUM_TABLES-1:0]        prov_sel, above, cand, pick;
    sched_state_e                 state_q;
    logic                         valid_q, taken_q, sweep_q, mis_q;
    tage_op_t                     op_q;
    logic [NUM_TABLES-1:0]        sel_q, useful_q;
    logic [31:0]                  pc_q, fail_q;
    logic [INDEX_WIDTH-1:0]       idx_q;
    logic [2:0]                   prov_q;
    logic [RESET_PERIOD_EXP2-1:0] per_q, per_d;
    logic                         pend_q, pend_d;

    assign in_s = {upd_pc_i, upd_taken_i, upd_provider_i, upd_mispredict_i, upd_useful_i};

    tage_update_fifo #(.WIDTH($bits(upd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (in_s),
        .pop_i   (pop),
        .data_o  (head_s),
        .count_o (count)
    );

    assign upd_ready_o = count != CW'(FIFO_DEPTH);
    assign push        = upd_valid_i && upd_ready_o;
    assign pop         = state_q == ST_IDLE && !pend_q && count != '0;
    assign fire        = valid_q && tbl_ready_i;
    assign sweep_done  = state_q == ST_SWEEP && fire && &idx_q;
    assign wrap        = pop && &per_q;
    assign per_d       = pop ? per_q + 1'b1 : per_q;
    // a wrap landing on the final sweep beat must still leave a sweep pending
    assign pend_d      = wrap || (pend_q && !sweep_done);
    assign go_alloc    = mis_q && int'(prov_q) < NUM_TABLES;

    always_comb begin
        prov_sel = '0;
        above    = '0;
        for (int k = 0; k < NUM_TABLES; k++) begin
            prov_sel[k] = int'(head_s.prov) == k + 1;
            above[k]    = k >= int'(prov_q);
        end
        cand = above & ~useful_q;
        pick = cand & (~cand + 1'b1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            op_q     <= TAGE_OP_CTR;
            sel_q    <= '0;
            pc_q     <= '0;
            taken_q  <= 1'b0;
            idx_q    <= '0;
            sweep_q  <= 1'b0;
            fail_q   <= '0;
            prov_q   <= '0;
            mis_q    <= 1'b0;
            useful_q <= '0;
            per_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            per_q  <= per_d;
            pend_q <= pend_d;
            case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        state_q <= ST_SWEEP;
                        valid_q <= 1'b1;
                        op_q    <= TAGE_OP_UCLR;
                        sel_q   <= '1;
                        sweep_q <= 1'b1;
                    end else if (pop) begin
                        state_q  <= ST_UPDATE;
                        valid_q  <= 1'b1;
                        op_q     <= TAGE_OP_CTR;
                        sel_q    <= prov_sel;
                        pc_q     <= head_s.pc;
                        taken_q  <= head_s.taken;
                        prov_q   <= head_s.prov;
                        mis_q    <= head_s.mis;
                        useful_q <= head_s.useful;
                    end
                end
                ST_UPDATE: begin
                    if (tbl_ready_i) begin
                        state_q <= go_alloc ? ST_ALLOC : ST_IDLE;
                        valid_q <= go_alloc;
                        if (go_alloc) begin
                            op_q   <= |cand ? TAGE_OP_ALLOC : TAGE_OP_UDEC;
                            sel_q  <= |cand ? pick : above;
                            fail_q <= fail_q + 32'(!(|cand));
                        end
                    end
                end
                ST_ALLOC: begin
                    if (tbl_ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (tbl_ready_i) begin
                        idx_q <= idx_q + 1'b1;
                        if (&idx_q) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                            sweep_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign tbl_req_valid_o    = valid_q;
    assign tbl_op_o           = op_q;
    assign tbl_sel_o          = sel_q;
    assign tbl_pc_o           = pc_q;
    assign tbl_taken_o        = taken_q;
    assign tbl_index_o        = idx_q;
    assign sweep_active_o     = sweep_q;
    assign alloc_fail_count_o = fail_q;
endmodule

// File: tb/tb_tage_update_scheduler.sv
// tb_tage_update_scheduler: directed vectors plus randomized traffic checked
// against an op-stream model of the TAGE update scheduler.
module tb_tage_update_scheduler;
    localparam int NT = 4;
    localparam int IW = 3;
    localparam int PE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          upd_valid_i = 1'b0;
    logic          upd_ready_o;
    logic [31:0]   upd_pc_i = '0;
    logic          upd_taken_i = 1'b0;
    logic [2:0]    upd_provider_i = '0;
    logic          upd_mispredict_i = 1'b0;
    logic [NT-1:0] upd_useful_i = '0;
    logic          tbl_req_valid_o;
    logic          tbl_ready_i;
    logic [1:0]    tbl_op_o;
    logic [NT-1:0] tbl_sel_o;
    logic [31:0]   tbl_pc_o;
    logic          tbl_taken_o;
    logic [IW-1:0] tbl_index_o;
    logic          sweep_active_o;
    logic [31:0]   alloc_fail_count_o;

    tage_update_scheduler #(.NUM_TABLES(NT), .FIFO_DEPTH(4), .INDEX_WIDTH(IW), .RESET_PERIOD_EXP2(PE)) dut (
        .clk(clk), .rst(rst), .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
        .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i), .upd_provider_i(upd_provider_i),
        .upd_mispredict_i(upd_mispredict_i), .upd_useful_i(upd_useful_i),
        .tbl_req_valid_o(tbl_req_valid_o), .tbl_ready_i(tbl_ready_i), .tbl_op_o(tbl_op_o),
        .tbl_sel_o(tbl_sel_o), .tbl_pc_o(tbl_pc_o), .tbl_taken_o(tbl_taken_o),
        .tbl_index_o(tbl_index_o), .sweep_active_o(sweep_active_o),
        .alloc_fail_count_o(alloc_fail_count_o)
    );

    typedef struct {
        logic [1:0]    op;
        logic [NT-1:0] sel;
        logic [31:0]   pc;
        logic          tk;
        logic [IW-1:0] idx;
        logic          sa;
    } op_t;
    typedef struct {
        logic [31:0] pc; logic tk; logic [2:0] pv; logic mis; logic [3:0] us;
        int n; logic [1:0] op0; logic [3:0] sel0; logic [1:0] op1; logic [3:0] sel1; int finc;
    } vec_t;

    op_t         exp_q[$], seen_q[$];
    op_t         g, e;
    vec_t        vt[6];
    int          n_checks = 0, n_fail = 0, pops = 0, fail_exp = 0;
    logic        rand_rdy = 1'b0, rdy_cmd = 1'b0, stalled = 1'b0, mok;
    logic [75:0] cur, hold;

    assign cur = {tbl_req_valid_o, tbl_op_o, tbl_sel_o, tbl_pc_o, tbl_taken_o, tbl_index_o,
                  sweep_active_o, alloc_fail_count_o};

    initial forever #5 clk = ~clk;
    initial begin
        tbl_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2 tbl_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_cmd;
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Reference model: the ordered list of table ops each accepted update must produce.
    task automatic model_push(input logic [31:0] pc, input logic tk, input logic [2:0] pv,
                              input logic mis, input logic [3:0] us);
        op_t o;
        int found = 0;
        logic [NT-1:0] above = '0;
        o = '{2'b00, '0, pc, tk, '0, 1'b0};
        if (pv != 0) o.sel[int'(pv) - 1] = 1'b1;
        exp_q.push_back(o);
        if (mis && pv < NT) begin
            for (int t = int'(pv) + 1; t <= NT; t++) begin
                above[t-1] = 1'b1;
                if (!us[t-1] && found == 0) found = t;
            end
            o.sel = '0;
            if (found != 0) begin
                o.op = 2'b01;
                o.sel[found-1] = 1'b1;
            end else begin
                o.op = 2'b11;
                o.sel = above;
                fail_exp++;
            end
            exp_q.push_back(o);
        end
        pops++;
        if (pops % (1 << PE) == 0)
            for (int i = 0; i < (1 << IW); i++) exp_q.push_back('{2'b10, '1, 32'h0, 1'b0, IW'(i), 1'b1});
    endtask

    task automatic offer(input logic [31:0] pc, input logic tk, input logic [2:0] pv, input logic mis,
                         input logic [3:0] us, input int max_w, output logic acc);
        int w = 0;
        acc = 1'b0;
        upd_pc_i = pc; upd_taken_i = tk; upd_provider_i = pv; upd_mispredict_i = mis; upd_useful_i = us;
        upd_valid_i = 1'b1;
        while (!acc && w < max_w) begin
            @(negedge clk);
            acc = upd_ready_o;
            @(posedge clk);
            w++;
        end
        #1 upd_valid_i = 1'b0;
        if (acc) model_push(pc, tk, pv, mis, us);
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [2:0] pv,
                        input logic mis, input logic [3:0] us);
        logic acc;
        offer(pc, tk, pv, mis, us, 500, acc);
        chk("push_accept", acc, 1);
    endtask

    task automatic wait_drain(input string nm);
        int w = 0;
        while ((exp_q.size() != 0 || tbl_req_valid_o) && w < 3000) begin
            @(posedge clk);
            #2;
            w++;
        end
        chk({nm, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete(); seen_q.delete(); pops = 0; fail_exp = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) stalled = 1'b0;
        else begin
            if (stalled) begin
                n_checks++;
                if (cur !== hold) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h expected %h", cur, hold);
                end
            end
            stalled = tbl_req_valid_o && !tbl_ready_i;
            hold = cur;
            if (tbl_req_valid_o && tbl_ready_i) begin
                g = '{tbl_op_o, tbl_sel_o, tbl_pc_o, tbl_taken_o, tbl_index_o, sweep_active_o};
                seen_q.push_back(g);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL op_stream: unexpected op=%0d sel=%b pc=%h", g.op, g.sel, g.pc);
                end else begin
                    e = exp_q.pop_front();
                    mok = g.op == e.op && g.sel == e.sel &&
                          (e.op == 2'b10 ? (g.idx == e.idx && g.sa) : (g.pc == e.pc && g.tk == e.tk && !g.sa));
                    if (!mok) begin
                        n_fail++;
                        $display("FAIL op_stream: got op=%0d sel=%b pc=%h tk=%b idx=%0d sa=%b expected op=%0d sel=%b pc=%h tk=%b idx=%0d",
                                 g.op, g.sel, g.pc, g.tk, g.idx, g.sa, e.op, e.sel, e.pc, e.tk, e.idx);
                    end
                end
            end
        end
    end

    initial begin
        logic acc, ok;
        logic [1:0] o0, o1;
        logic [3:0] s0, s1;
        logic [31:0] p0;
        int fexp, bad;
        vt[0] = '{32'h1000, 1'b1, 3'd1, 1'b1, 4'b0010, 2, 2'b00, 4'b0001, 2'b01, 4'b0100, 0};
        vt[1] = '{32'h2000, 1'b0, 3'd2, 1'b1, 4'b1100, 2, 2'b00, 4'b0010, 2'b11, 4'b1100, 1};
        vt[2] = '{32'h3000, 1'b1, 3'd0, 1'b1, 4'b0000, 2, 2'b00, 4'b0000, 2'b01, 4'b0001, 0};
        vt[3] = '{32'h4000, 1'b0, 3'd4, 1'b1, 4'b1111, 1, 2'b00, 4'b1000, 2'b00, 4'b0000, 0};
        vt[4] = '{32'h5000, 1'b1, 3'd3, 1'b0, 4'b0000, 1, 2'b00, 4'b0100, 2'b00, 4'b0000, 0};
        vt[5] = '{32'h6000, 1'b0, 3'd3, 1'b1, 4'b0111, 2, 2'b00, 4'b0100, 2'b01, 4'b1000, 0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_values", {tbl_req_valid_o, tbl_op_o, tbl_sel_o, tbl_pc_o, tbl_taken_o, tbl_index_o,
                             sweep_active_o, alloc_fail_count_o, upd_ready_o}, 77'd1);
        @(posedge clk);
        #1 rdy_cmd = 1'b1;
        // request latency: accept at N, idle at N..N+1, request visible N+1..N+2
        push(32'hABC0, 1'b1, 3'd2, 1'b0, 4'b0000);
        @(negedge clk);
        chk("latency_n1", tbl_req_valid_o, 0);
        @(negedge clk);
        chk("latency_n2", {tbl_req_valid_o, tbl_op_o, tbl_sel_o, tbl_pc_o, tbl_taken_o},
            {1'b1, 2'b00, 4'b0010, 32'hABC0, 1'b1});
        @(posedge clk);
        #1 wait_drain("latency");
        fexp = 0;
        for (int i = 0; i < 6; i++) begin
            seen_q.delete();
            push(vt[i].pc, vt[i].tk, vt[i].pv, vt[i].mis, vt[i].us);
            wait_drain("vec");
            fexp += vt[i].finc;
            {o0, s0, p0, o1, s1} = '0;
            if (seen_q.size() > 0) begin o0 = seen_q[0].op; s0 = seen_q[0].sel; p0 = seen_q[0].pc; end
            if (seen_q.size() > 1) begin o1 = seen_q[1].op; s1 = seen_q[1].sel; end
            chk($sformatf("vec%0d", i), {8'(seen_q.size()), o0, s0, p0, o1, s1, alloc_fail_count_o},
                {8'(vt[i].n), vt[i].op0, vt[i].sel0, vt[i].pc, vt[i].op1, vt[i].sel1, 32'(fexp)});
        end
        // sweep after the 8th pop, with the queue accepting during the sweep
        do_reset();
        for (int i = 0; i < 8; i++) push(32'h100 + i, i[0], 3'd1, 1'b0, 4'b0000);
        bad = 0;
        while (!sweep_active_o && bad < 100) begin @(posedge clk); #1; bad++; end
        chk("sweep_start", sweep_active_o, 1);
        offer(32'h200, 1'b1, 3'd2, 1'b0, 4'b0000, 2, acc);
        chk("accept_in_sweep0", {acc, sweep_active_o}, 2'b11);
        offer(32'h201, 1'b0, 3'd3, 1'b0, 4'b0000, 2, acc);
        chk("accept_in_sweep1", acc, 1);
        wait_drain("sweep");
        ok = seen_q.size() == 18;
        for (int i = 0; i < 8 && ok; i++)
            ok = seen_q[i].op == 2'b00 && seen_q[i].pc == 32'h100 + i && seen_q[8+i].op == 2'b10 &&
                 seen_q[8+i].idx == IW'(i) && seen_q[8+i].sa && seen_q[8+i].sel == 4'hF;
        if (ok) ok = seen_q[16].pc == 32'h200 && seen_q[17].pc == 32'h201 && seen_q[17].op == 2'b00;
        chk("sweep_order", ok, 1);
        @(negedge clk);
        chk("sweep_end", {sweep_active_o, tbl_index_o}, 0);
        // queue fill while tables stall, then drain in order
        do_reset();
        rdy_cmd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(32'h300 + i, i[1], 3'(i % 5), i[0], 4'b0101, 2, acc);
            chk("fill_accept", acc, 1);
        end
        @(negedge clk);
        chk("fill_full", upd_ready_o, 0);
        @(posedge clk);
        #1 offer(32'h305, 1'b1, 3'd1, 1'b1, 4'b1111, 3, acc);
        chk("fill_blocked", acc, 0);
        rdy_cmd = 1'b1;
        push(32'h305, 1'b1, 3'd1, 1'b1, 4'b1111);
        wait_drain("fill");
        chk("fill_fail_count", alloc_fail_count_o, fail_exp);
        // reset asserted mid-ALLOC with two entries queued
        do_reset();
        rdy_cmd = 1'b0;
        push(32'h400, 1'b1, 3'd1, 1'b1, 4'b0000);
        repeat (3) begin @(posedge clk); #1; end
        rdy_cmd = 1'b1;
        @(posedge clk);
        #1 rdy_cmd = 1'b0;
        push(32'h401, 1'b0, 3'd2, 1'b0, 4'b0000);
        push(32'h402, 1'b1, 3'd3, 1'b0, 4'b0000);
        @(negedge clk);
        chk("alloc_pre", {tbl_req_valid_o, tbl_op_o, tbl_sel_o, tbl_pc_o}, {1'b1, 2'b01, 4'b0010, 32'h400});
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete(); pops = 0; fail_exp = 0;
        #1 chk("async_reset", {tbl_req_valid_o, tbl_op_o, tbl_sel_o, tbl_pc_o, tbl_taken_o, tbl_index_o,
                               sweep_active_o, alloc_fail_count_o, upd_ready_o}, 77'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        rdy_cmd = 1'b1;
        seen_q.delete();
        bad = 0;
        repeat (10) begin @(negedge clk); if (tbl_req_valid_o) bad++; end
        chk("no_op_after_reset", {bad[7:0], 8'(seen_q.size())}, 0);
        @(posedge clk);
        #1 push(32'h500, 1'b0, 3'd0, 1'b0, 4'b0000);
        wait_drain("post_reset");
        chk("post_reset_ops", seen_q.size(), 1);
        // randomized traffic with random table back-pressure
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            push($urandom, 1'($urandom), 3'($urandom_range(0, 4)), 1'($urandom), 4'($urandom));
        end
        rand_rdy = 1'b0;
        rdy_cmd = 1'b1;
        wait_drain("random");
        chk("random_fail_count", alloc_fail_count_o, fail_exp);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
